alu_bist: RTL and testbench
===========================

ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter N_RANDOM, default 64, is the number of pseudo-random vectors applied after the directed set (range 1..1024).
REQ-002 Parameter SEED, default 64'h0123456789ABCDEF, is the LFSR reload value; a value of 0 SHALL be replaced by 64'h1.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset.
REQ-005 start  input  1  is a one-cycle request to begin a self-test run.
REQ-006 busy  output  1  is high while vectors are being applied.
REQ-007 done  output  1  is high from run completion until the next accepted start or reset.
REQ-008 pass  output  1  equals done AND (fail_count == 0).
REQ-009 fail_count  output  8  counts mismatching vectors and saturates at 255.
REQ-010 alu_a, alu_b  output  64  are the registered operands driven to the ALU under test.
REQ-011 alu_ctrl  output  4  is the registered ALUControl driven to the ALU under test.
REQ-012 alu_result  input  64  is the result returned by the ALU under test.
REQ-013 alu_zero  input  1  is the zero flag returned by the ALU under test.

Function
REQ-014 The FSM SHALL have four states: IDLE, DIRECTED, RANDOM and DONE.
REQ-015 Transitions: IDLE->DIRECTED on start; DIRECTED->RANDOM after 25 vectors; RANDOM->DONE after N_RANDOM vectors; DONE->DIRECTED on start.
REQ-016 start SHALL be ignored while busy.
REQ-017 An accepted start SHALL clear fail_count and done and reload the LFSR with SEED.
REQ-018 Exactly one vector SHALL be applied per cycle, and the operands and alu_ctrl SHALL be held stable for that whole cycle.
REQ-019 The ALU under test is combinational, so alu_result/alu_zero SHALL be sampled at the clock edge that ends the vector's cycle.
REQ-020 The op order within each group of 5 vectors SHALL be AND(0000), OR(0001), ADD(0010), SUB(0110), PASS_B(0111).
REQ-021 Directed operand pairs (a,b) SHALL be applied in this order, each pair with all 5 ops: (1,1); (-1,-1); (1,-1); (64'h0123456789ABCDEF,0); (64'h8000000000000000,64'h8000000000000000).
REQ-022 Random phase: a = lfsr and b = {lfsr[31:0],lfsr[63:32]}, with the op taken from the 5-op rotation; the LFSR SHALL advance once per random vector.
REQ-023 The LFSR SHALL be a 64-bit Galois LFSR with polynomial x^64+x^63+x^61+x^60+1.
REQ-024 The internal reference model SHALL compute, from the registered operands: a&b, a|b, a+b, a-b or b, each modulo 2^64 with no carry/overflow flag; expected zero = (expected == 0).
REQ-025 A mismatch is (alu_result !== expected) OR (alu_zero !== expected zero); X or Z on the inputs SHALL count as a mismatch.
REQ-026 Each mismatch SHALL increment fail_count by 1, saturating at 255.
REQ-027 In IDLE and DONE: alu_a = 0, alu_b = 0, alu_ctrl = 4'b0000, and no comparison is performed.

Reset
REQ-028 reset SHALL force the FSM to IDLE with busy=0, done=0, pass=0, fail_count=0, alu_a=0, alu_b=0, alu_ctrl=0, and LFSR=SEED.
REQ-029 Reset asserted mid-run SHALL abort the run immediately, with no completion indication.
REQ-030 reset SHALL take priority over a start asserted in the same cycle.

Configuration
REQ-031 With ALU_BIST_STOP_ON_FAIL_EN defined, the first mismatch SHALL move the FSM to DONE on the following edge, with fail_count=1 and alu_a/alu_b/alu_ctrl frozen at the failing vector.
REQ-032 Without ALU_BIST_STOP_ON_FAIL_EN, all 25+N_RANDOM vectors SHALL always be applied.

Structure
REQ-033 alu_pkg SHALL hold the ALU op constants (AND/OR/ADD/SUB/PASS_B), the directed operand constants, and the FSM state typedef.
REQ-034 The LFSR SHALL be implemented as sub-module lfsr64 (ports clk, reset, load, advance, seed, q).

Verification
REQ-035 Correct ALU model, N_RANDOM=64: start -> busy high for exactly 89 cycles -> done=1, pass=1, fail_count=0.
REQ-036 ALU with ADD faulted to a|b -> the directed phase alone yields fail_count=4 (pairs 1, 2, 3 and 5); the total SHALL match the bench's own model.
REQ-037 ALU with zero tied to 0 -> directed phase yields fail_count=7 (AND/PASS_B on pair 4, ADD on pairs 3 and 5, SUB on pairs 1, 2 and 5).
REQ-038 reset at cycle 10 of a run -> the next cycle shows busy=0, done=0, fail_count=0, outputs 0; a new start reruns identically (same fail_count).
REQ-039 start re-pulsed while busy -> ignored, total run length unchanged; start in DONE -> a new run with fail_count cleared.
REQ-040 ALU_BIST_STOP_ON_FAIL_EN defined with the ADD fault -> DONE reached after vector 3 with alu_ctrl=0010, alu_a=1, alu_b=1, fail_count=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encodings, directed operand table, BIST state type
// and the golden ALU function shared by the self-test engine.
package alu_pkg;

  localparam logic [3:0] c_OP_AND    = 4'b0000;
  localparam logic [3:0] c_OP_OR     = 4'b0001;
  localparam logic [3:0] c_OP_ADD    = 4'b0010;
  localparam logic [3:0] c_OP_SUB    = 4'b0110;
  localparam logic [3:0] c_OP_PASS_B = 4'b0111;

  localparam logic [63:0] c_DIR_A0 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] c_DIR_B0 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] c_DIR_A1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_DIR_B1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_DIR_A2 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] c_DIR_B2 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_DIR_A3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] c_DIR_B3 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] c_DIR_A4 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] c_DIR_B4 = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIRECTED = 2'd1,
    ST_RANDOM   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic [3:0] op_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    return c_OP_AND;
      3'd1:    return c_OP_OR;
      3'd2:    return c_OP_ADD;
      3'd3:    return c_OP_SUB;
      default: return c_OP_PASS_B;
    endcase
  endfunction

  function automatic logic [63:0] dir_a(input logic [2:0] idx);
    case (idx)
      3'd0:    return c_DIR_A0;
      3'd1:    return c_DIR_A1;
      3'd2:    return c_DIR_A2;
      3'd3:    return c_DIR_A3;
      default: return c_DIR_A4;
    endcase
  endfunction

  function automatic logic [63:0] dir_b(input logic [2:0] idx);
    case (idx)
      3'd0:    return c_DIR_B0;
      3'd1:    return c_DIR_B1;
      3'd2:    return c_DIR_B2;
      3'd3:    return c_DIR_B3;
      default: return c_DIR_B4;
    endcase
  endfunction

  function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
    case (op)
      c_OP_AND:    return a & b;
      c_OP_OR:     return a | b;
      c_OP_ADD:    return a + b;
      c_OP_SUB:    return a - b;
      c_OP_PASS_B: return b;
      default:     return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: operand/control/result bus between the BIST engine and the ALU under test.
`default_nettype none
interface alu_bist_if;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_zero;

  modport master (output alu_a, alu_b, alu_ctrl, input alu_result, alu_zero);
  modport slave  (input alu_a, alu_b, alu_ctrl, output alu_result, alu_zero);
endinterface
`default_nettype wire

// File: rtl/lfsr64.sv
// lfsr64: 64-bit right-shifting Galois LFSR, polynomial x^64+x^63+x^61+x^60+1.
`default_nettype none
module lfsr64 (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        load,
  input  wire logic        advance,
  input  wire logic [63:0] seed,
  output logic      [63:0] q
);
  localparam logic [63:0] c_TAPS = 64'hD800_0000_0000_0000;

  logic [63:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_q <= seed;
    end else if (advance) begin
      r_q <= {1'b0, r_q[63:1]} ^ (r_q[0] ? c_TAPS : 64'd0);
    end
  end

  assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/alu_bist.sv
// alu_bist: built-in self test for a 64-bit combinational ALU (25 directed + N_RANDOM LFSR vectors).
// Optional ALU_BIST_STOP_ON_FAIL_EN: stop at the first mismatch, freezing the failing vector.
`default_nettype none
module alu_bist
  import alu_pkg::*;
#(
  parameter int          N_RANDOM = 64,
  parameter logic [63:0] SEED     = 64'h0123_4567_89AB_CDEF
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       start,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      fail_count,
  alu_bist_if.master      bus
);
  localparam logic [63:0] c_SEED  = (SEED == 64'd0) ? 64'd1 : SEED;
  localparam logic [9:0]  c_RLAST = 10'(N_RANDOM - 1);

  state_t      r_state, w_state_nxt;
  logic [63:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [3:0]  r_ctrl, w_ctrl_nxt;
  logic [7:0]  r_fail, w_fail_nxt;
  logic [2:0]  r_op, r_pair, w_op_nxt, w_pair_nxt, w_op_inc, w_pair_inc;
  logic [9:0]  r_rcnt, w_rcnt_nxt;
  logic [63:0] w_lfsr_q, w_exp;
  logic        w_load, w_adv, w_active, w_mismatch;

  lfsr64 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .advance (w_adv),
    .seed    (c_SEED),
    .q       (w_lfsr_q)
  );

  assign w_active   = (r_state == ST_DIRECTED) || (r_state == ST_RANDOM);
  assign w_exp      = alu_ref(r_a, r_b, r_ctrl);
  // Case inequality so X/Z returned by the ALU counts as a failure.
  assign w_mismatch = w_active && ((bus.alu_result !== w_exp) ||
                                   (bus.alu_zero !== (w_exp == 64'd0)));
  assign w_op_inc   = (r_op == 3'd4) ? 3'd0 : r_op + 3'd1;
  assign w_pair_inc = (r_op == 3'd4) ? r_pair + 3'd1 : r_pair;

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_ctrl_nxt  = r_ctrl;
    w_op_nxt    = r_op;
    w_pair_nxt  = r_pair;
    w_rcnt_nxt  = r_rcnt;
    w_fail_nxt  = r_fail;
    w_load      = 1'b0;
    w_adv       = 1'b0;

    if (w_mismatch && (r_fail != 8'hFF)) w_fail_nxt = r_fail + 8'd1;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_DIRECTED;
          w_a_nxt     = dir_a(3'd0);
          w_b_nxt     = dir_b(3'd0);
          w_ctrl_nxt  = op_sel(3'd0);
          w_op_nxt    = 3'd0;
          w_pair_nxt  = 3'd0;
          w_fail_nxt  = 8'd0;
          w_load      = 1'b1;
        end
      end
      ST_DIRECTED: begin
        if ((r_op == 3'd4) && (r_pair == 3'd4)) begin
          w_state_nxt = ST_RANDOM;
          w_a_nxt     = w_lfsr_q;
          w_b_nxt     = {w_lfsr_q[31:0], w_lfsr_q[63:32]};
          w_ctrl_nxt  = op_sel(3'd0);
          w_op_nxt    = 3'd0;
          w_rcnt_nxt  = 10'd0;
          w_adv       = 1'b1;
        end else begin
          w_a_nxt     = dir_a(w_pair_inc);
          w_b_nxt     = dir_b(w_pair_inc);
          w_ctrl_nxt  = op_sel(w_op_inc);
          w_op_nxt    = w_op_inc;
          w_pair_nxt  = w_pair_inc;
        end
      end
      ST_RANDOM: begin
        if (r_rcnt == c_RLAST) begin
          w_state_nxt = ST_DONE;
          w_a_nxt     = 64'd0;
          w_b_nxt     = 64'd0;
          w_ctrl_nxt  = 4'd0;
        end else begin
          w_a_nxt     = w_lfsr_q;
          w_b_nxt     = {w_lfsr_q[31:0], w_lfsr_q[63:32]};
          w_ctrl_nxt  = op_sel(w_op_inc);
          w_op_nxt    = w_op_inc;
          w_rcnt_nxt  = r_rcnt + 10'd1;
          w_adv       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    if (w_mismatch) begin
      w_state_nxt = ST_DONE;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_ctrl_nxt  = r_ctrl;
      w_adv       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= 64'd0;
      r_b     <= 64'd0;
      r_ctrl  <= 4'd0;
      r_fail  <= 8'd0;
      r_op    <= 3'd0;
      r_pair  <= 3'd0;
      r_rcnt  <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_fail  <= w_fail_nxt;
      r_op    <= w_op_nxt;
      r_pair  <= w_pair_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  assign busy         = w_active;
  assign done         = (r_state == ST_DONE);
  assign pass         = done && (r_fail == 8'd0);
  assign fail_count   = r_fail;
  assign bus.alu_a    = r_a;
  assign bus.alu_b    = r_b;
  assign bus.alu_ctrl = r_ctrl;
endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
// tb_alu_bist: drives alu_bist with a behavioural (optionally faulted) ALU and checks against a vector-list model.
`timescale 1ns/1ps
`default_nettype none
module tb_alu_bist;
  localparam int          NR     = 64;
  localparam int          NV     = 25 + NR;
  localparam logic [63:0] SEED_V = 64'h0123_4567_89AB_CDEF;
`ifdef ALU_BIST_STOP_ON_FAIL_EN
  localparam int RST_FM = 0;
  localparam int RST_DIR = 0;
`else
  localparam int RST_FM = 1;
  localparam int RST_DIR = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, pass;
  logic [7:0] fail_count;
  int         fault_mode = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [63:0] exp_a [NV];
  logic [63:0] exp_b [NV];
  logic [3:0]  exp_op[NV];

  alu_bist_if u_if ();

  alu_bist #(.N_RANDOM(NR), .SEED(SEED_V)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .bus        (u_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] good_alu(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return 64'd0;
    endcase
  endfunction

  // fm: 0 = healthy, 1 = ADD behaves as OR, 2 = zero flag stuck at 0
  function automatic logic [63:0] dut_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op, input int fm);
    if (fm == 1 && op == 4'b0010) return a | b;
    return good_alu(a, b, op);
  endfunction

  assign u_if.alu_result = dut_alu(u_if.alu_a, u_if.alu_b, u_if.alu_ctrl, fault_mode);
  assign u_if.alu_zero   = (fault_mode == 2) ? 1'b0 : (u_if.alu_result == 64'd0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build_vectors();
    logic [3:0]  ops[5];
    logic [63:0] pa[5];
    logic [63:0] pb[5];
    int          taps[4];
    logic [63:0] mask, lf;
    ops  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    pa   = '{64'd1, '1, 64'd1, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000};
    pb   = '{64'd1, '1, '1, 64'd0, 64'h8000_0000_0000_0000};
    taps = '{64, 63, 61, 60};
    mask = 64'd0;
    foreach (taps[k]) mask[taps[k]-1] = 1'b1;
    for (int p = 0; p < 5; p++)
      for (int o = 0; o < 5; o++) begin
        exp_a[p*5+o] = pa[p];
        exp_b[p*5+o] = pb[p];
        exp_op[p*5+o] = ops[o];
      end
    lf = SEED_V;
    for (int j = 0; j < NR; j++) begin
      exp_a[25+j]  = lf;
      exp_b[25+j]  = {lf[31:0], lf[63:32]};
      exp_op[25+j] = ops[j % 5];
      lf = lf[0] ? ((lf >> 1) ^ mask) : (lf >> 1);
    end
  endtask

  function automatic int model_fails(input int fm, input int upto);
    int f;
    logic [63:0] g, r;
    logic z;
    f = 0;
    for (int i = 0; i < upto; i++) begin
      g = good_alu(exp_a[i], exp_b[i], exp_op[i]);
      r = dut_alu(exp_a[i], exp_b[i], exp_op[i], fm);
      z = (fm == 2) ? 1'b0 : (r == 64'd0);
      if (((r != g) || (z != (g == 64'd0))) && f < 255) f++;
    end
    return f;
  endfunction

  task automatic idle_gap();
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic do_run(input int fm, input int exp_dir, input bit repulse, input string tag);
    int cyc;
    int rp_cyc;
    int mf;
    cyc    = 0;
    rp_cyc = $urandom_range(1, NV - 2);
    mf     = model_fails(fm, NV);
    fault_mode = fm;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    check({tag, "_clr_fail"}, 64'(fail_count), 64'd0);
    check({tag, "_clr_done"}, 64'(done), 64'd0);
    while (busy === 1'b1 && cyc < NV + 20) begin
      if (cyc < NV) begin
        check({tag, "_a"}, u_if.alu_a, exp_a[cyc]);
        check({tag, "_b"}, u_if.alu_b, exp_b[cyc]);
        check({tag, "_op"}, 64'(u_if.alu_ctrl), 64'(exp_op[cyc]));
      end
      if (repulse && cyc == rp_cyc) start = 1'b1;
      @(posedge clk); #1; start = 1'b0; cyc++;
      if (cyc == 25) check({tag, "_dir_fails"}, 64'(fail_count), 64'(exp_dir));
    end
    check({tag, "_busy_len"}, 64'(cyc), 64'(NV));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_fails"}, 64'(fail_count), 64'(mf));
    check({tag, "_pass"}, 64'(pass), (mf == 0) ? 64'd1 : 64'd0);
    check({tag, "_idle_a"}, u_if.alu_a, 64'd0);
    check({tag, "_idle_ctrl"}, 64'(u_if.alu_ctrl), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    build_vectors();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_fail", 64'(fail_count), 64'd0);
    check("rst_a", u_if.alu_a, 64'd0);
    check("rst_b", u_if.alu_b, 64'd0);
    check("rst_ctrl", 64'(u_if.alu_ctrl), 64'd0);

    start = 1'b1; @(posedge clk); #1;
    check("rst_vs_start_busy", 64'(busy), 64'd0);
    reset = 1'b0; start = 1'b0;

    idle_gap();
    do_run(0, 0, 1'b0, "good");
    idle_gap();
    do_run(0, 0, 1'b1, "repulse");
`ifdef ALU_BIST_STOP_ON_FAIL_EN
    begin
      int cyc;
      cyc = 0;
      fault_mode = 1;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      while (busy === 1'b1 && cyc < NV + 20) begin @(posedge clk); #1; cyc++; end
      check("stop_len", 64'(cyc), 64'd3);
      check("stop_done", 64'(done), 64'd1);
      check("stop_pass", 64'(pass), 64'd0);
      check("stop_fail", 64'(fail_count), 64'd1);
      check("stop_ctrl", 64'(u_if.alu_ctrl), 64'h2);
      check("stop_a", u_if.alu_a, 64'd1);
      check("stop_b", u_if.alu_b, 64'd1);
    end
`else
    idle_gap();
    do_run(1, 4, 1'b0, "addflt");
    do_run(2, 7, 1'b1, "zeroflt");
`endif

    fault_mode = RST_FM;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1; @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_fail", 64'(fail_count), 64'd0);
    check("abort_a", u_if.alu_a, 64'd0);
    check("abort_b", u_if.alu_b, 64'd0);
    check("abort_ctrl", 64'(u_if.alu_ctrl), 64'd0);
    reset = 1'b0;
    idle_gap();
    do_run(RST_FM, RST_DIR, 1'b0, "rerun");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
